// File: rtl/rv32im_pkg.sv
// Shared types and constants for the RV32IM multiply/divide sequencing logic.
package rv32im_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } mdu_state_e;

    localparam logic [31:0] MDU_TIMEOUT_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Bundle of controller/MDU/write-back signals around the MDU sequencer.
interface mdu_sequencer_if;

    logic        is_mdu;
    logic        reg_write_en_in;
    logic        mdu_ready;
    logic [31:0] mdu_result;
    logic        mdu_valid;
    logic        stall;
    logic        reg_write_en_out;
    logic [31:0] result;
    logic        busy;
    logic        timeout_err;

    // Master is the surrounding datapath (controller, MDU, write-back).
    modport master (
        output is_mdu, reg_write_en_in, mdu_ready, mdu_result,
        input  mdu_valid, stall, reg_write_en_out, result, busy, timeout_err
    );

    modport slave (
        input  is_mdu, reg_write_en_in, mdu_ready, mdu_result,
        output mdu_valid, stall, reg_write_en_out, result, busy, timeout_err
    );

endinterface

// File: rtl/mdu_timeout_cnt.sv
// Clear/increment counter with a terminal-count flag, used to bound MDU waits.
module mdu_timeout_cnt #(
    parameter int unsigned     WIDTH    = 6,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only; the combinational
    // next-state block above uses blocking assignments with a default first.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/mdu_sequencer.sv
// Freezes PC and register write around a multi-cycle MDU operation, issues the
// start pulse, waits for completion (bounded) and presents one write-back cycle.
module mdu_sequencer
    import rv32im_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    mdu_sequencer_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        timeout_err_q, timeout_err_d;

    logic cnt_clr;
    logic cnt_inc;
    logic cnt_tc;
    logic mdu_valid;
    logic stall;
    logic reg_write_en;

    // The counter sits at 0 throughout IDLE and ISSUE and already counts the
    // ISSUE cycle, so TIMEOUT_CYCLES covers ISSUE plus WAIT and WB lands in
    // cycle TIMEOUT_CYCLES+1.
    mdu_timeout_cnt #(
        .WIDTH    (CNT_W),
        .TERMINAL (CNT_W'(TIMEOUT_CYCLES - 1))
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        mdu_valid     = 1'b0;
        stall         = 1'b1;
        reg_write_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall        = bus.is_mdu;
                reg_write_en = bus.reg_write_en_in & ~bus.is_mdu;
                cnt_clr      = 1'b1;
                if (bus.is_mdu) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mdu_valid = 1'b1;
                cnt_inc   = 1'b1;
                if (bus.mdu_ready) begin
                    result_d = bus.mdu_result;
                    state_d  = WB;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A ready on the terminal cycle takes priority over the timeout.
                if (bus.mdu_ready) begin
                    result_d = bus.mdu_result;
                    state_d  = WB;
                end else if (cnt_tc) begin
                    result_d      = MDU_TIMEOUT_RESULT;
                    timeout_err_d = 1'b1;
                    state_d       = WB;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WB: begin
                stall        = 1'b0;
                reg_write_en = bus.reg_write_en_in;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.mdu_valid        = mdu_valid;
    assign bus.stall            = stall;
    assign bus.reg_write_en_out = reg_write_en;
    assign bus.result           = result_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.timeout_err      = timeout_err_q;

endmodule
